// File: rtl/uart_pkg.sv
// Shared UART timing definitions.
//
// Holds the default widths and oversample ratio for the baud generator,
// plus the integer divisors for the common 1.8432 MHz reference clock.
// calc_divisor() returns the integer divisor for any clock/baud pair.
package uart_pkg;

  localparam int unsigned DIV_W_DEF      = 16;
  localparam int unsigned FRAC_W_DEF     = 4;
  localparam int unsigned OVERSAMPLE_DEF = 16;

  localparam int unsigned REF_CLK_HZ     = 1_843_200;
  localparam int unsigned DIV_9600       = 12;
  localparam int unsigned DIV_115200     = 1;

  // Integer part of clk_hz / (baud * oversample); the remainder is what
  // the fractional divisor is meant to absorb.
  function automatic int unsigned calc_divisor(input int unsigned clk_hz,
                                               input int unsigned baud,
                                               input int unsigned oversample);
    return clk_hz / (baud * oversample);
  endfunction

endpackage

// File: rtl/baud_oversample_counter.sv
// Oversample counter for the baud generator.
//
// Counts baud ticks 0..OVERSAMPLE-1 and produces one-cycle strobes that
// line up with the baud tick on which the count wraps (bit_tick) and the
// tick on which it passes the half-bit point (mid_tick).
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   clear     in   forces the count and strobes to 0 (stopped or re-sync)
//   baud_tick in   baud tick decode, same cycle the parent registers it
//   bit_tick  out  registered, aligned with the wrapping baud tick
//   mid_tick  out  registered, aligned with the half-bit baud tick
module baud_oversample_counter
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic baud_tick,
  output logic bit_tick,
  output logic mid_tick
);

  localparam int unsigned OSC_W = $clog2(OVERSAMPLE);
  localparam logic [OSC_W-1:0] OSC_LAST = OSC_W'(OVERSAMPLE - 1);
  localparam logic [OSC_W-1:0] OSC_MID  = OSC_W'(OVERSAMPLE / 2 - 1);

  logic [OSC_W-1:0] osc;
  logic [OSC_W-1:0] osc_next;

  always_comb begin
    osc_next = (osc == OSC_LAST) ? '0 : osc + OSC_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      osc      <= '0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
    end else if (clear) begin
      osc      <= '0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
    end else begin
      bit_tick <= baud_tick && (osc == OSC_LAST);
      mid_tick <= baud_tick && (osc == OSC_MID);
      if (baud_tick) begin
        osc <= osc_next;
      end
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Fractional baud-rate generator with oversample strobes.
//
// Divides CLK by N + F/2^FRAC_W. Each period is N cycles, stretched to
// N+1 when the fractional accumulator carries. Produces the 16x baud clock,
// a one-cycle BAUD_TICK per period, and BIT_TICK/MID_TICK every
// OVERSAMPLE ticks. Divisor writes go through a shadow register and are
// applied only at a period boundary, on SYNC, or while stopped.
//
// Ports:
//   CLK          in   system clock, rising edge
//   RST_N        in   asynchronous active-low reset
//   EN           in   generator enable
//   DIVISOR      in   integer divisor N (captured on DIV_LOAD)
//   DIV_FRAC     in   fractional divisor F (captured on DIV_LOAD)
//   DIV_LOAD     in   strobe, captures DIVISOR/DIV_FRAC into the shadow
//   SYNC         in   strobe, restarts period/oversample counters
//   BAUDOUT_CLK  out  divided clock, high ceil(P/2) cycles per period
//   BAUD_TICK    out  one-cycle pulse per period
//   BIT_TICK     out  one-cycle pulse every OVERSAMPLE baud ticks
//   MID_TICK     out  one-cycle pulse at the middle baud tick of a bit
//   DIV_ACTIVE   out  integer divisor in use
//   DIV_PENDING  out  shadow holds a value not yet applied
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W      = DIV_W_DEF,
  parameter int unsigned FRAC_W     = FRAC_W_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned DIV_RST    = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic [DIV_W-1:0]  DIVISOR,
  input  logic [FRAC_W-1:0] DIV_FRAC,
  input  logic              DIV_LOAD,
  input  logic              SYNC,
  output logic              BAUDOUT_CLK,
  output logic              BAUD_TICK,
  output logic              BIT_TICK,
  output logic              MID_TICK,
  output logic [DIV_W-1:0]  DIV_ACTIVE,
  output logic              DIV_PENDING
);

  localparam logic [DIV_W:0] ONE = {{DIV_W{1'b0}}, 1'b1};

  // Active and shadow divisors
  logic [DIV_W-1:0]  act_n;
  logic [FRAC_W-1:0] act_f;
  logic [DIV_W-1:0]  shd_n;
  logic [FRAC_W-1:0] shd_f;
  logic              pending;

  // Period state; cnt is one bit wider so N = 2^DIV_W-1 plus carry fits
  logic [DIV_W:0]    cnt;
  logic [FRAC_W-1:0] acc;
  logic              p_long;

  // Decodes
  logic              running;
  logic [DIV_W:0]    period;
  logic [DIV_W:0]    last_cnt;
  logic [DIV_W:0]    half_up;
  logic              at_end;
  logic              tick_ok;
  logic              apply;
  logic [DIV_W-1:0]  nxt_n;
  logic [FRAC_W-1:0] nxt_f;
  logic [FRAC_W:0]   acc_sum;
  logic              osc_clear;

  always_comb begin
    running  = EN && (act_n != '0);
    period   = {1'b0, act_n} + {{DIV_W{1'b0}}, p_long};
    last_cnt = period - ONE;
    half_up  = (period + ONE) >> 1;
    at_end   = running && (cnt == last_cnt);
    // SYNC swallows a tick that would land in the same cycle
    tick_ok  = at_end && !SYNC;
    // A load in the same cycle as an apply point bypasses the shadow so
    // the new value takes effect at that very edge
    nxt_n    = DIV_LOAD ? DIVISOR  : shd_n;
    nxt_f    = DIV_LOAD ? DIV_FRAC : shd_f;
    apply    = (DIV_LOAD || pending) && (!running || at_end || SYNC);
    acc_sum  = {1'b0, acc} + {1'b0, act_f};
    osc_clear = !running || SYNC;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      act_n       <= DIV_W'(DIV_RST);
      act_f       <= '0;
      shd_n       <= '0;
      shd_f       <= '0;
      pending     <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      p_long      <= 1'b0;
      BAUD_TICK   <= 1'b0;
      BAUDOUT_CLK <= 1'b0;
    end else begin
      BAUD_TICK   <= tick_ok;
      BAUDOUT_CLK <= running && (cnt < half_up);

      if (!running || SYNC) begin
        cnt    <= '0;
        acc    <= '0;
        p_long <= 1'b0;
      end else if (at_end) begin
        cnt    <= '0;
        acc    <= acc_sum[FRAC_W-1:0];
        p_long <= acc_sum[FRAC_W];
      end else begin
        cnt    <= cnt + ONE;
      end

      if (DIV_LOAD) begin
        shd_n <= DIVISOR;
        shd_f <= DIV_FRAC;
      end

      // Apply overrides the accumulator update above: a new divisor always
      // starts with a plain N-cycle period
      if (apply) begin
        act_n   <= nxt_n;
        act_f   <= nxt_f;
        pending <= 1'b0;
        acc     <= '0;
        p_long  <= 1'b0;
      end else if (DIV_LOAD) begin
        pending <= 1'b1;
      end
    end
  end

  assign DIV_ACTIVE  = act_n;
  assign DIV_PENDING = pending;

  baud_oversample_counter #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_osc (
    .clk       (CLK),
    .rst_n     (RST_N),
    .clear     (osc_clear),
    .baud_tick (tick_ok),
    .bit_tick  (BIT_TICK),
    .mid_tick  (MID_TICK)
  );

endmodule

// File: tb/tb_baud_tick_gen.sv
module tb_baud_tick_gen;
  import uart_pkg::*;

  localparam int unsigned TB_DIV_W  = 16;
  localparam int unsigned TB_FRAC_W = 4;
  localparam int unsigned TB_OS     = 16;
  localparam int unsigned TB_RST    = DIV_9600;

  logic                 CLK = 1'b0;
  logic                 RST_N;
  logic                 EN;
  logic [TB_DIV_W-1:0]  DIVISOR;
  logic [TB_FRAC_W-1:0] DIV_FRAC;
  logic                 DIV_LOAD;
  logic                 SYNC;
  logic                 BAUDOUT_CLK;
  logic                 BAUD_TICK;
  logic                 BIT_TICK;
  logic                 MID_TICK;
  logic [TB_DIV_W-1:0]  DIV_ACTIVE;
  logic                 DIV_PENDING;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  int baud_q[$];
  int bit_q[$];
  int mid_q[$];
  int seen_q[$];

  baud_tick_gen #(
    .DIV_W      (TB_DIV_W),
    .FRAC_W     (TB_FRAC_W),
    .OVERSAMPLE (TB_OS),
    .DIV_RST    (TB_RST)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .EN          (EN),
    .DIVISOR     (DIVISOR),
    .DIV_FRAC    (DIV_FRAC),
    .DIV_LOAD    (DIV_LOAD),
    .SYNC        (SYNC),
    .BAUDOUT_CLK (BAUDOUT_CLK),
    .BAUD_TICK   (BAUD_TICK),
    .BIT_TICK    (BIT_TICK),
    .MID_TICK    (MID_TICK),
    .DIV_ACTIVE  (DIV_ACTIVE),
    .DIV_PENDING (DIV_PENDING)
  );

  always #5 CLK = ~CLK;

  // cyc = number of rising edges seen so far
  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard: pop the expected cycle of each strobe when the DUT shows it
  always @(negedge CLK) begin : monitor
    int e;
    if (mon_en) begin
      if (BAUD_TICK) begin
        seen_q.push_back(cyc);
        checks++;
        if (baud_q.size() == 0) begin
          failures++;
          $display("FAIL baud_tick unexpected at cycle %0d", cyc);
        end else begin
          e = baud_q.pop_front();
          if (cyc !== e) begin
            failures++;
            $display("FAIL baud_tick time got=%0d exp=%0d", cyc, e);
          end
        end
      end
      if (BIT_TICK) begin
        checks++;
        if (bit_q.size() == 0) begin
          failures++;
          $display("FAIL bit_tick unexpected at cycle %0d", cyc);
        end else begin
          e = bit_q.pop_front();
          if (cyc !== e) begin
            failures++;
            $display("FAIL bit_tick time got=%0d exp=%0d", cyc, e);
          end
        end
      end
      if (MID_TICK) begin
        checks++;
        if (mid_q.size() == 0) begin
          failures++;
          $display("FAIL mid_tick unexpected at cycle %0d", cyc);
        end else begin
          e = mid_q.pop_front();
          if (cyc !== e) begin
            failures++;
            $display("FAIL mid_tick time got=%0d exp=%0d", cyc, e);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) step();
  endtask

  // Inputs sampled at the next edge; returns one cycle later
  task automatic load(input int n, input int f);
    DIVISOR  = TB_DIV_W'(n);
    DIV_FRAC = TB_FRAC_W'(f);
    DIV_LOAD = 1'b1;
    step();
    DIV_LOAD = 1'b0;
  endtask

  // Load while stopped (applies at once), then enable; z = edge after
  // which cnt is 0, so ticks land on z+P, z+2P, ...
  task automatic start(input int n, input int f, output int z);
    EN = 1'b0;
    load(n, f);
    EN = 1'b1;
    z  = cyc;
  endtask

  task automatic do_reset();
    mon_en   = 1'b0;
    RST_N    = 1'b0;
    EN       = 1'b0;
    DIV_LOAD = 1'b0;
    SYNC     = 1'b0;
    DIVISOR  = '0;
    DIV_FRAC = '0;
    step();
    step();
    RST_N = 1'b1;
    step();
    baud_q.delete();
    bit_q.delete();
    mid_q.delete();
    seen_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({BAUD_TICK, BAUDOUT_CLK, BIT_TICK, MID_TICK, DIV_PENDING} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=00000",
               {BAUD_TICK, BAUDOUT_CLK, BIT_TICK, MID_TICK, DIV_PENDING});
    end
    checks++;
    if (DIV_ACTIVE !== TB_DIV_W'(TB_RST)) begin
      failures++;
      $display("FAIL reset_div_active got=%0d exp=%0d", DIV_ACTIVE, TB_RST);
    end
  endtask

  task automatic test_basic();
    int z;
    logic exp_b;
    do_reset();
    start(3, 0, z);
    checks++;
    if (DIV_ACTIVE !== 16'd3 || DIV_PENDING !== 1'b0) begin
      failures++;
      $display("FAIL basic_apply got=%0d/%b exp=3/0", DIV_ACTIVE, DIV_PENDING);
    end
    for (int k = 1; k <= 33; k++) baud_q.push_back(z + 3 * k);
    mid_q.push_back(z + 24);
    mid_q.push_back(z + 72);
    bit_q.push_back(z + 48);
    bit_q.push_back(z + 96);
    mon_en = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      step();
      exp_b = ((j - 1) % 3) != 2;
      checks++;
      if (BAUDOUT_CLK !== exp_b) begin
        failures++;
        $display("FAIL basic_baudout cyc=%0d got=%b exp=%b", j, BAUDOUT_CLK, exp_b);
      end
    end
    wait_until(z + 100);
    mon_en = 1'b0;
    checks++;
    if (baud_q.size() + bit_q.size() + mid_q.size() != 0) begin
      failures++;
      $display("FAIL basic_missing got=%0d exp=0", baud_q.size() + bit_q.size() + mid_q.size());
    end
  endtask

  task automatic test_frac();
    int z, t, acc, pl, s, span;
    do_reset();
    start(4, 8, z);
    t = z; acc = 0; pl = 0;
    for (int k = 1; k <= 17; k++) begin
      t += 4 + pl;
      baud_q.push_back(t);
      if (k == 8)  mid_q.push_back(t);
      if (k == 16) bit_q.push_back(t);
      s   = acc + 8;
      pl  = (s >= 16) ? 1 : 0;
      acc = s % 16;
    end
    mon_en = 1'b1;
    wait_until(t + 1);
    mon_en = 1'b0;
    span = (seen_q.size() >= 17) ? seen_q[16] - seen_q[0] : -1;
    checks++;
    if (span != 72) begin
      failures++;
      $display("FAIL frac_span got=%0d exp=72", span);
    end
    checks++;
    if (baud_q.size() + bit_q.size() + mid_q.size() != 0) begin
      failures++;
      $display("FAIL frac_missing got=%0d exp=0", baud_q.size() + bit_q.size() + mid_q.size());
    end
  endtask

  task automatic test_reload();
    int z, min_gap;
    do_reset();
    start(3, 0, z);
    baud_q = '{z + 3, z + 6, z + 11, z + 16, z + 21, z + 26};
    mon_en = 1'b1;
    wait_until(z + 4);
    load(7, 0);
    checks++;
    if (DIV_PENDING !== 1'b1 || DIV_ACTIVE !== 16'd3) begin
      failures++;
      $display("FAIL reload_pending got=%b/%0d exp=1/3", DIV_PENDING, DIV_ACTIVE);
    end
    // Second load lands on the boundary cycle: overwrites and applies there
    load(5, 0);
    checks++;
    if (DIV_PENDING !== 1'b0 || DIV_ACTIVE !== 16'd5) begin
      failures++;
      $display("FAIL reload_applied got=%b/%0d exp=0/5", DIV_PENDING, DIV_ACTIVE);
    end
    wait_until(z + 27);
    mon_en = 1'b0;
    min_gap = 1000;
    for (int i = 1; i < seen_q.size(); i++)
      if (seen_q[i] - seen_q[i-1] < min_gap) min_gap = seen_q[i] - seen_q[i-1];
    checks++;
    if (min_gap < 3) begin
      failures++;
      $display("FAIL reload_min_gap got=%0d exp>=3", min_gap);
    end
    checks++;
    if (baud_q.size() + bit_q.size() + mid_q.size() != 0) begin
      failures++;
      $display("FAIL reload_missing got=%0d exp=0", baud_q.size() + bit_q.size() + mid_q.size());
    end
  endtask

  task automatic test_sync();
    int z;
    do_reset();
    start(3, 0, z);
    baud_q.push_back(z + 3);
    baud_q.push_back(z + 6);
    for (int t = z + 12; t <= z + 60; t += 3) baud_q.push_back(t);
    mid_q.push_back(z + 33);
    bit_q.push_back(z + 57);
    mon_en = 1'b1;
    wait_until(z + 8);
    SYNC = 1'b1;
    step();
    SYNC = 1'b0;
    checks++;
    if (BAUD_TICK !== 1'b0) begin
      failures++;
      $display("FAIL sync_suppress got=%b exp=0", BAUD_TICK);
    end
    wait_until(z + 61);
    mon_en = 1'b0;
    checks++;
    if (baud_q.size() + bit_q.size() + mid_q.size() != 0) begin
      failures++;
      $display("FAIL sync_missing got=%0d exp=0", baud_q.size() + bit_q.size() + mid_q.size());
    end
  endtask

  task automatic test_n1_stop();
    int z;
    do_reset();
    start(1, 0, z);
    for (int k = 1; k <= 7; k++) baud_q.push_back(z + k);
    mon_en = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      step();
      checks++;
      if (BAUDOUT_CLK !== 1'b1) begin
        failures++;
        $display("FAIL n1_baudout cyc=%0d got=%b exp=1", j, BAUDOUT_CLK);
      end
    end
    load(0, 0);
    checks++;
    if (DIV_ACTIVE !== 16'd0) begin
      failures++;
      $display("FAIL stop_div_active got=%0d exp=0", DIV_ACTIVE);
    end
    step();
    checks++;
    if ({BAUD_TICK, BAUDOUT_CLK, BIT_TICK, MID_TICK, DIV_PENDING} !== 5'b0) begin
      failures++;
      $display("FAIL stop_outputs got=%b exp=00000",
               {BAUD_TICK, BAUDOUT_CLK, BIT_TICK, MID_TICK, DIV_PENDING});
    end
    wait_until(z + 9);
    mon_en = 1'b0;
    checks++;
    if (baud_q.size() + bit_q.size() + mid_q.size() != 0) begin
      failures++;
      $display("FAIL stop_missing got=%0d exp=0", baud_q.size() + bit_q.size() + mid_q.size());
    end
  endtask

  task automatic test_async_reset();
    int z;
    do_reset();
    start(3, 0, z);
    wait_until(z + 3);
    checks++;
    if (BAUD_TICK !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre_tick got=%b exp=1", BAUD_TICK);
    end
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({BAUD_TICK, BAUDOUT_CLK, BIT_TICK, MID_TICK, DIV_PENDING} !== 5'b0) begin
      failures++;
      $display("FAIL areset_outputs got=%b exp=00000",
               {BAUD_TICK, BAUDOUT_CLK, BIT_TICK, MID_TICK, DIV_PENDING});
    end
    checks++;
    if (DIV_ACTIVE !== TB_DIV_W'(TB_RST)) begin
      failures++;
      $display("FAIL areset_div_active got=%0d exp=%0d", DIV_ACTIVE, TB_RST);
    end
    step();
    EN = 1'b0;
    #3;
    RST_N = 1'b1;
    step();
    checks++;
    if (DIV_ACTIVE !== TB_DIV_W'(TB_RST) || BAUD_TICK !== 1'b0) begin
      failures++;
      $display("FAIL areset_release got=%0d/%b exp=%0d/0", DIV_ACTIVE, BAUD_TICK, TB_RST);
    end
  endtask

  task automatic test_en_toggle();
    int z;
    do_reset();
    start(3, 0, z);
    baud_q = '{z + 3, z + 6, z + 13, z + 16};
    mon_en = 1'b1;
    wait_until(z + 7);
    EN = 1'b0;
    step();
    checks++;
    if (BAUD_TICK !== 1'b0 || BAUDOUT_CLK !== 1'b0) begin
      failures++;
      $display("FAIL en_off_outputs got=%b%b exp=00", BAUD_TICK, BAUDOUT_CLK);
    end
    wait_until(z + 10);
    EN = 1'b1;
    wait_until(z + 17);
    mon_en = 1'b0;
    checks++;
    if (baud_q.size() + bit_q.size() + mid_q.size() != 0) begin
      failures++;
      $display("FAIL en_missing got=%0d exp=0", baud_q.size() + bit_q.size() + mid_q.size());
    end
  endtask

  initial begin
    RST_N    = 1'b0;
    EN       = 1'b0;
    DIV_LOAD = 1'b0;
    SYNC     = 1'b0;
    DIVISOR  = '0;
    DIV_FRAC = '0;
    test_reset();
    test_basic();
    test_frac();
    test_reload();
    test_sync();
    test_n1_stop();
    test_async_reset();
    test_en_toggle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
